crf_sequencer: RTL and testbench

Configuration register file and frame sequencer for the up-sampling accelerator. It holds the UPSTART/UPEND control bits that drive access_control and accepts host register reads and writes over a simple valid/ready bus. It also merges the single-cycle status writes coming back from access_control, counts AXI-Stream beats per frame, and runs a run/done/timeout state machine that raises a host interrupt.

---
 rtl/crf_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_crf_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crf_sequencer.sv
// crf_sequencer: configuration register file and frame sequencer for the
// up-sampling accelerator.
//
// Holds the UPSTART/UPEND control bits that drive access_control, serves host
// register reads/writes, merges single-cycle status writes from
// access_control, counts AXI-Stream beats per frame and runs a
// run/done/timeout FSM that raises a level interrupt.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   host_wvalid/wready/waddr/wdata   host write channel
//   host_rvalid_req/raddr            host read request (always accepted)
//   host_rvalid/rdata                registered read response, 1 cycle later
//   ac_crf_wrt/waddr/wdata           status write from access_control
//   ac_crf_processing                access_control busy flag (STATUS bit2)
//   ac_crf_axisi_*, ac_crf_axiso_*   stream handshakes used for beat counting
//   crf_ac_UPSTART/UPEND             CTRL[0]/CTRL[1]
//   crf_ac_wbusy                     host CTRL write stalled this cycle
//   irq                              level interrupt
//
// Register map (decoded on addr[4:2])
//   0x00 CTRL  RW  bit0 UPSTART, bit1 UPEND, bit8 DONE_IE, bit9 TO_IE
//   0x04 IN_BEATS  RO
//   0x08 OUT_BEATS RO
//   0x0C TIMEOUT   RW  stall limit, 0 disables the watchdog
//   0x10 STATUS    RO  [1:0] state, bit2 ac_crf_processing
//
// FSM states
//   state | meaning
//   IDLE  | waiting for CTRL[1:0] = 01
//   RUN   | frame in progress, beats and stalls counted
//   DONE  | frame finished (CTRL[1:0] = 10), waits for host to clear CTRL
//   TMO   | stall watchdog fired, waits for host to clear CTRL

module crf_sequencer #(
   parameter int CRF_DATA_WIDTH = 32,
   parameter int CRF_ADDR_WIDTH = 32,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      host_wvalid,
   output logic                      host_wready,
   input  logic [CRF_ADDR_WIDTH-1:0] host_waddr,
   input  logic [CRF_DATA_WIDTH-1:0] host_wdata,
   input  logic                      host_rvalid_req,
   input  logic [CRF_ADDR_WIDTH-1:0] host_raddr,
   output logic                      host_rvalid,
   output logic [CRF_DATA_WIDTH-1:0] host_rdata,
   input  logic                      ac_crf_wrt,
   input  logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
   input  logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
   input  logic                      ac_crf_processing,
   input  logic                      ac_crf_axisi_tvalid,
   input  logic                      ac_crf_axisi_tready,
   input  logic                      ac_crf_axiso_tvalid,
   input  logic                      ac_crf_axiso_tready,
   output logic                      crf_ac_UPSTART,
   output logic                      crf_ac_UPEND,
   output logic                      crf_ac_wbusy,
   output logic                      irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_TMO  = 2'd3;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_IN     = 3'd1;
   localparam logic [2:0] A_OUT    = 3'd2;
   localparam logic [2:0] A_TMO    = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;

   // Only the defined CTRL bits are stored; the rest read back as 0.
   localparam logic [9:0] CTRL_MASK = 10'h303;

   logic [1:0]                state_q, state_d;
   logic [9:0]                ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]      timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0]      in_beats_q, in_beats_d;
   logic [CNT_WIDTH-1:0]      out_beats_q, out_beats_d;
   logic [CNT_WIDTH-1:0]      stall_q, stall_d;
   logic                      irq_q, irq_d;
   logic                      rvalid_q, rvalid_d;
   logic [CRF_DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                      host_sel_ctrl;
   logic                      ac_ctrl_wr;
   logic                      host_wr;
   logic                      host_clear;
   logic                      in_hs;
   logic                      out_hs;
   logic [CRF_DATA_WIDTH-1:0] rd_mux;
   logic                      unused_bits;

   assign host_sel_ctrl = (host_waddr[4:2] == A_CTRL);
   assign ac_ctrl_wr    = ac_crf_wrt & (ac_crf_waddr[4:2] == A_CTRL);
   // Only a host write that targets CTRL can collide with the status write.
   assign host_wready   = ~(ac_ctrl_wr & host_sel_ctrl);
   assign host_wr       = host_wvalid & host_wready;
   assign host_clear    = host_wr & host_sel_ctrl & (host_wdata[1:0] == 2'b00);
   assign in_hs         = ac_crf_axisi_tvalid & ac_crf_axisi_tready;
   assign out_hs        = ac_crf_axiso_tvalid & ac_crf_axiso_tready;

   assign crf_ac_UPSTART = ctrl_q[0];
   assign crf_ac_UPEND   = ctrl_q[1];
   assign crf_ac_wbusy   = host_wvalid & host_sel_ctrl & ~host_wready;
   assign irq            = irq_q;
   assign host_rvalid    = rvalid_q;
   assign host_rdata     = rdata_q;

   // Address bits outside [4:2] and upper status-data bits are ignored.
   assign unused_bits = ^{host_waddr[1:0], host_waddr[CRF_ADDR_WIDTH-1:5],
                          host_raddr[1:0], host_raddr[CRF_ADDR_WIDTH-1:5],
                          ac_crf_waddr[1:0], ac_crf_waddr[CRF_ADDR_WIDTH-1:5],
                          ac_crf_wdata[CRF_DATA_WIDTH-1:2]};

   always_comb begin
      rd_mux = '0;
      case (host_raddr[4:2])
         A_CTRL:   rd_mux = CRF_DATA_WIDTH'(ctrl_q);
         A_IN:     rd_mux = CRF_DATA_WIDTH'(in_beats_q);
         A_OUT:    rd_mux = CRF_DATA_WIDTH'(out_beats_q);
         A_TMO:    rd_mux = CRF_DATA_WIDTH'(timeout_q);
         A_STATUS: rd_mux = CRF_DATA_WIDTH'({ac_crf_processing, state_q});
         default:  rd_mux = '0;
      endcase
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      timeout_d   = timeout_q;
      state_d     = state_q;
      in_beats_d  = in_beats_q;
      out_beats_d = out_beats_q;
      stall_d     = stall_q;
      rvalid_d    = host_rvalid_req;
      rdata_d     = rdata_q;

      if (host_rvalid_req) begin
         rdata_d = rd_mux;
      end

      if (host_wr && host_sel_ctrl) begin
         ctrl_d = host_wdata[9:0] & CTRL_MASK;
      end
      if (host_wr && (host_waddr[4:2] == A_TMO)) begin
         timeout_d = CNT_WIDTH'(host_wdata);
      end
      // Status write lands on the same edge; the host CTRL write is stalled then.
      if (ac_ctrl_wr) begin
         ctrl_d[1:0] = ac_crf_wdata[1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (ctrl_d[1:0] == 2'b01) begin
               state_d     = ST_RUN;
               in_beats_d  = '0;
               out_beats_d = '0;
               stall_d     = '0;
            end
         end
         ST_RUN: begin
            if (in_hs && !(&in_beats_q)) begin
               in_beats_d = in_beats_q + CNT_WIDTH'(1);
            end
            if (out_hs && !(&out_beats_q)) begin
               out_beats_d = out_beats_q + CNT_WIDTH'(1);
            end
            if (in_hs || out_hs) begin
               stall_d = '0;
            end else if (!(&stall_q)) begin
               stall_d = stall_q + CNT_WIDTH'(1);
            end
            // DONE takes priority over a watchdog expiring on the same edge.
            if (ctrl_d[1:0] == 2'b10) begin
               state_d = ST_DONE;
            end else if ((timeout_q != '0) && (stall_d >= timeout_q)) begin
               state_d = ST_TMO;
            end
         end
         ST_DONE, ST_TMO: begin
            if (host_clear) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      irq_d = ((state_q == ST_DONE) & ctrl_q[8]) | ((state_q == ST_TMO) & ctrl_q[9]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ctrl_q      <= '0;
         timeout_q   <= '0;
         in_beats_q  <= '0;
         out_beats_q <= '0;
         stall_q     <= '0;
         irq_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         timeout_q   <= timeout_d;
         in_beats_q  <= in_beats_d;
         out_beats_q <= out_beats_d;
         stall_q     <= stall_d;
         irq_q       <= irq_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_crf_sequencer.sv
// Self-checking bench for crf_sequencer: register table, directed frame
// sequences and a randomized run against a behavioural model.

module tb_crf_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_wvalid;
   logic        host_wready;
   logic [31:0] host_waddr;
   logic [31:0] host_wdata;
   logic        host_rvalid_req;
   logic [31:0] host_raddr;
   logic        host_rvalid;
   logic [31:0] host_rdata;
   logic        ac_crf_wrt;
   logic [31:0] ac_crf_waddr;
   logic [31:0] ac_crf_wdata;
   logic        ac_crf_processing;
   logic        ac_crf_axisi_tvalid, ac_crf_axisi_tready;
   logic        ac_crf_axiso_tvalid, ac_crf_axiso_tready;
   logic        crf_ac_UPSTART, crf_ac_UPEND, crf_ac_wbusy, irq;

   always #5 clk = ~clk;

   crf_sequencer dut (
      .clk(clk), .rst(rst),
      .host_wvalid(host_wvalid), .host_wready(host_wready),
      .host_waddr(host_waddr), .host_wdata(host_wdata),
      .host_rvalid_req(host_rvalid_req), .host_raddr(host_raddr),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .ac_crf_wrt(ac_crf_wrt), .ac_crf_waddr(ac_crf_waddr), .ac_crf_wdata(ac_crf_wdata),
      .ac_crf_processing(ac_crf_processing),
      .ac_crf_axisi_tvalid(ac_crf_axisi_tvalid), .ac_crf_axisi_tready(ac_crf_axisi_tready),
      .ac_crf_axiso_tvalid(ac_crf_axiso_tvalid), .ac_crf_axiso_tready(ac_crf_axiso_tready),
      .crf_ac_UPSTART(crf_ac_UPSTART), .crf_ac_UPEND(crf_ac_UPEND),
      .crf_ac_wbusy(crf_ac_wbusy), .irq(irq)
   );

   typedef struct {
      bit          rst;
      bit          wv;
      logic [31:0] wa;
      logic [31:0] wd;
      bit          rr;
      logic [31:0] ra;
      bit          acw;
      logic [31:0] aca;
      logic [31:0] acd;
      bit          proc;
      bit          iv, ir, ov, orr;
   } in_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;   // read: expected rdata; write: expected wready
   } vec_t;

   int tests = 0;
   int fails = 0;

   // Behavioural model: state numbering is the STATUS encoding (0..3).
   logic [31:0] m_ctrl, m_tmo, m_in, m_out, m_stall, m_rdata;
   int          m_state;
   bit          m_irq, m_rvalid;

   function automatic in_t idle();
      in_t x;
      x = '{default: 0};
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input in_t x);
      logic [31:0] nctrl, ntmo, rv;
      bit sel, ac_hit, acc, clr, ihs, ohs;
      if (x.rst) begin
         m_ctrl = 0; m_tmo = 0; m_in = 0; m_out = 0; m_stall = 0;
         m_rdata = 0; m_state = 0; m_irq = 0; m_rvalid = 0;
         return;
      end
      case (x.ra[4:2])
         3'd0:    rv = m_ctrl;
         3'd1:    rv = m_in;
         3'd2:    rv = m_out;
         3'd3:    rv = m_tmo;
         3'd4:    rv = (32'(x.proc) << 2) | 32'(m_state);
         default: rv = 0;
      endcase
      m_rvalid = x.rr;
      if (x.rr) m_rdata = rv;
      m_irq = (m_state == 2 && m_ctrl[8]) || (m_state == 3 && m_ctrl[9]);

      sel    = (x.wa[4:2] == 3'd0);
      ac_hit = x.acw && (x.aca[4:2] == 3'd0);
      acc    = x.wv && !(ac_hit && sel);
      clr    = acc && sel && (x.wd[1:0] == 2'b00);
      nctrl  = m_ctrl;
      ntmo   = m_tmo;
      if (acc && sel) nctrl = x.wd & 32'h303;
      if (acc && x.wa[4:2] == 3'd3) ntmo = x.wd;
      if (ac_hit) nctrl[1:0] = x.acd[1:0];
      ihs = x.iv && x.ir;
      ohs = x.ov && x.orr;

      case (m_state)
         0: if (nctrl[1:0] == 2'b01) begin
               m_state = 1; m_in = 0; m_out = 0; m_stall = 0;
            end
         1: begin
               if (ihs && m_in != 32'hFFFF_FFFF) m_in++;
               if (ohs && m_out != 32'hFFFF_FFFF) m_out++;
               if (ihs || ohs) m_stall = 0;
               else if (m_stall != 32'hFFFF_FFFF) m_stall++;
               if (nctrl[1:0] == 2'b10) m_state = 2;
               else if (m_tmo != 0 && m_stall >= m_tmo) m_state = 3;
            end
         default: if (clr) m_state = 0;
      endcase
      m_ctrl = nctrl;
      m_tmo  = ntmo;
   endtask

   // One clock: drive, check combinational outputs, clock, check registered ones.
   task automatic cycle(input in_t x, output logic rdy);
      bit sel, ac_hit, e_rdy;
      rst = x.rst; host_wvalid = x.wv; host_waddr = x.wa; host_wdata = x.wd;
      host_rvalid_req = x.rr; host_raddr = x.ra;
      ac_crf_wrt = x.acw; ac_crf_waddr = x.aca; ac_crf_wdata = x.acd;
      ac_crf_processing = x.proc;
      ac_crf_axisi_tvalid = x.iv; ac_crf_axisi_tready = x.ir;
      ac_crf_axiso_tvalid = x.ov; ac_crf_axiso_tready = x.orr;
      #1;
      sel    = (x.wa[4:2] == 3'd0);
      ac_hit = x.acw && (x.aca[4:2] == 3'd0);
      e_rdy  = !(ac_hit && sel);
      chk("wready", 32'(host_wready), 32'(e_rdy));
      chk("wbusy", 32'(crf_ac_wbusy), 32'(x.wv && sel && !e_rdy));
      rdy = host_wready;
      @(posedge clk);
      model_edge(x);
      #1;
      chk("rvalid", 32'(host_rvalid), 32'(m_rvalid));
      if (m_rvalid) chk("rdata", host_rdata, m_rdata);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("upstart", 32'(crf_ac_UPSTART), 32'(m_ctrl[0]));
      chk("upend", 32'(crf_ac_UPEND), 32'(m_ctrl[1]));
   endtask

   task automatic idle_cycle();
      logic r;
      cycle(idle(), r);
   endtask

   task automatic do_reset();
      in_t x;
      logic r;
      x = idle();
      x.rst = 1;
      cycle(x, r);
      cycle(x, r);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      in_t x;
      logic r;
      x = idle();
      x.rr = 1; x.ra = a;
      cycle(x, r);
      d = host_rdata;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic rdy);
      in_t x;
      x = idle();
      x.wv = 1; x.wa = a; x.wd = d;
      cycle(x, rdy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[14];
      in_t         x;
      logic [31:0] d;
      logic        r;
      int          n;

      vecs[0]  = '{0, 32'h00, 32'h0,         32'h0};
      vecs[1]  = '{0, 32'h04, 32'h0,         32'h0};
      vecs[2]  = '{0, 32'h08, 32'h0,         32'h0};
      vecs[3]  = '{0, 32'h0C, 32'h0,         32'h0};
      vecs[4]  = '{0, 32'h10, 32'h0,         32'h0};
      vecs[5]  = '{1, 32'h0C, 32'h55,        32'h1};
      vecs[6]  = '{0, 32'h0C, 32'h0,         32'h55};
      vecs[7]  = '{1, 32'h00, 32'hFFFF_F302, 32'h1};
      vecs[8]  = '{0, 32'h00, 32'h0,         32'h302};
      vecs[9]  = '{0, 32'h1C, 32'h0,         32'h0};
      vecs[10] = '{1, 32'h14, 32'hDEAD,      32'h1};
      vecs[11] = '{0, 32'h10, 32'h0,         32'h0};
      vecs[12] = '{0, 32'h03, 32'h0,         32'h302};
      vecs[13] = '{1, 32'h00, 32'h0,         32'h1};

      do_reset();
      chk("reset_irq", 32'(irq), 32'h0);
      chk("reset_upstart", 32'(crf_ac_UPSTART), 32'h0);
      chk("reset_upend", 32'(crf_ac_UPEND), 32'h0);
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            wr(vecs[i].addr, vecs[i].data, r);
            chk($sformatf("vec%0d_wready", i), 32'(r), vecs[i].exp);
         end else begin
            rd(vecs[i].addr, d);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
         end
      end

      // Full frame: 100 input beats, 50 output beats, DONE with interrupt.
      do_reset();
      wr(32'h00, 32'h101, r);
      rd(32'h10, d);
      chk("t2_status_run", d, 32'h1);
      for (int i = 0; i < 100; i++) begin
         x = idle();
         x.iv = 1; x.ir = 1;
         x.ov = (i < 50); x.orr = (i < 50);
         cycle(x, r);
      end
      x = idle();
      x.acw = 1; x.aca = 32'h0; x.acd = 32'h0;
      cycle(x, r);
      rd(32'h10, d);
      chk("t2_status_still_run", d, 32'h1);
      x.acd = 32'h2;
      cycle(x, r);
      chk("t2_irq_not_yet", 32'(irq), 32'h0);
      idle_cycle();
      chk("t2_irq_done", 32'(irq), 32'h1);
      rd(32'h04, d);
      chk("t2_in_beats", d, 32'd100);
      rd(32'h08, d);
      chk("t2_out_beats", d, 32'd50);
      rd(32'h10, d);
      chk("t2_status_done", d, 32'h2);
      wr(32'h00, 32'h100, r);
      idle_cycle();
      chk("t2_irq_cleared", 32'(irq), 32'h0);
      rd(32'h10, d);
      chk("t2_status_idle", d, 32'h0);

      // Collision: status write wins, host write retried next cycle.
      do_reset();
      x = idle();
      x.wv = 1; x.wa = 32'h0; x.wd = 32'h1;
      x.acw = 1; x.aca = 32'h0; x.acd = 32'h2;
      cycle(x, r);
      chk("t3_wready_stall", 32'(r), 32'h0);
      chk("t3_upend", 32'(crf_ac_UPEND), 32'h1);
      chk("t3_upstart", 32'(crf_ac_UPSTART), 32'h0);
      x.acw = 0;
      cycle(x, r);
      chk("t3_wready_retry", 32'(r), 32'h1);
      chk("t3_upstart_after", 32'(crf_ac_UPSTART), 32'h1);
      chk("t3_upend_after", 32'(crf_ac_UPEND), 32'h0);

      // Watchdog: no handshakes, TMO 10 cycles after RUN entry, irq one later.
      do_reset();
      wr(32'h0C, 32'd10, r);
      wr(32'h00, 32'h201, r);
      n = 0;
      while (n < 40) begin
         idle_cycle();
         n++;
         if (irq) break;
      end
      chk("t4_irq_cycles", n, 32'd11);
      rd(32'h10, d);
      chk("t4_status_tmo", d, 32'h3);
      wr(32'h00, 32'h200, r);
      idle_cycle();
      chk("t4_irq_cleared", 32'(irq), 32'h0);
      chk("t4_upstart_cleared", 32'(crf_ac_UPSTART), 32'h0);

      // Watchdog restart: handshake on the 9th cycle after entry.
      do_reset();
      wr(32'h0C, 32'd10, r);
      wr(32'h00, 32'h201, r);
      n = 0;
      while (n < 40) begin
         x = idle();
         n++;
         if (n == 9) begin x.iv = 1; x.ir = 1; end
         cycle(x, r);
         if (irq) break;
      end
      chk("t4_restart_cycles", n, 32'd20);

      // Reset mid-frame clears everything.
      do_reset();
      wr(32'h0C, 32'd50, r);
      wr(32'h00, 32'h301, r);
      for (int i = 0; i < 5; i++) begin
         x = idle();
         x.iv = 1; x.ir = 1; x.ov = 1; x.orr = 1;
         cycle(x, r);
      end
      x = idle();
      x.rst = 1; x.rr = 1; x.ra = 32'h04;
      cycle(x, r);
      chk("t5_irq", 32'(irq), 32'h0);
      chk("t5_upstart", 32'(crf_ac_UPSTART), 32'h0);
      chk("t5_rvalid", 32'(host_rvalid), 32'h0);
      chk("t5_rdata", host_rdata, 32'h0);
      for (int i = 0; i < 5; i++) begin
         rd(32'(i * 4), d);
         chk($sformatf("t5_reg%0d", i), d, 32'h0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         x = idle();
         x.rst = ($urandom_range(0, 299) == 0);
         x.wv  = ($urandom_range(0, 3) == 0);
         x.wa  = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         x.wd  = (x.wa[4:2] == 3'd3) ? 32'($urandom_range(0, 12)) : $urandom;
         x.rr  = $urandom_range(0, 1);
         x.ra  = 32'($urandom_range(0, 31));
         x.acw = ($urandom_range(0, 7) == 0);
         x.aca = $urandom_range(0, 1) ? 32'h0 : 32'h4;
         x.acd = 32'($urandom_range(0, 3));
         x.proc = $urandom_range(0, 1);
         x.iv  = $urandom_range(0, 1);
         x.ir  = $urandom_range(0, 1);
         x.ov  = ($urandom_range(0, 3) == 0);
         x.orr = $urandom_range(0, 1);
         cycle(x, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
